// File: rtl/instr_prefetch_unit_if.sv
// ============================================================================
//  Module      : instr_prefetch_unit_if
//  Description : Fetch-port and instruction-memory bus bundle for the
//                instruction prefetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_prefetch_unit_if;
    logic        instruction_request_i;
    logic [31:0] instruction_addr_i;
    logic        flush_bus_i;
    logic        instruction_response_o;
    logic [31:0] instruction_data_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    // slave: the prefetch unit itself
    modport slave (
        input  instruction_request_i, instruction_addr_i, flush_bus_i,
        input  mem_ack_i, mem_data_i,
        output instruction_response_o, instruction_data_o,
        output mem_req_o, mem_addr_o
    );

    // master: the IF/ID stage and memory surrounding the unit
    modport master (
        output instruction_request_i, instruction_addr_i, flush_bus_i,
        output mem_ack_i, mem_data_i,
        input  instruction_response_o, instruction_data_o,
        input  mem_req_o, mem_addr_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
// ============================================================================
//  Module      : instr_prefetch_unit
//  Description : Word-granular instruction prefetch queue with zero-latency
//                head lookup, sequential advance and redirect/discard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_prefetch_unit_if.slave  bus
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    logic [29:0]        tag_q  [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [c_PTR_W-1:0] head_q, head_d, tail_q, tail_d, w_next_idx;
    logic [c_CNT_W-1:0] count_q, count_d, w_occupancy;
    logic [29:0]        fetch_addr_q, fetch_addr_d;
    state_t             state_q;
    logic               outstanding_q, discard_q, mem_req_q;
    logic [31:0]        mem_addr_q;

    logic [29:0]        w_pc_tag;
    logic               w_head_match, w_next_match, w_hit, w_advance;
    logic               w_redirect, w_push, w_pop, w_unused;

    assign w_pc_tag     = bus.instruction_addr_i[31:2];
    assign w_unused     = ^bus.instruction_addr_i[1:0];
    assign w_next_idx   = head_q + c_PTR_W'(1);
    assign w_head_match = (count_q != '0) && (tag_q[head_q] == w_pc_tag);
    assign w_next_match = (count_q >= c_CNT_W'(2)) && (tag_q[w_next_idx] == w_pc_tag);
    assign w_hit        = bus.instruction_request_i && w_head_match;
    assign w_advance    = bus.instruction_request_i && !w_head_match && w_next_match;

    // An empty queue only redirects when the PC is not the word being fetched.
    assign w_redirect   = bus.flush_bus_i ||
                          (bus.instruction_request_i && !w_head_match && !w_next_match &&
                           ((count_q != '0) || (fetch_addr_q != w_pc_tag)));
    assign w_pop        = w_advance && !bus.flush_bus_i;
    assign w_push       = (state_q == S_REQ) && bus.mem_ack_i && !discard_q && !w_redirect;
    assign w_occupancy  = count_q + c_CNT_W'(outstanding_q);

    assign bus.instruction_response_o = w_hit;
    assign bus.instruction_data_o     = w_hit ? data_q[head_q] : 32'h0;
    assign bus.mem_req_o              = mem_req_q;
    assign bus.mem_addr_o             = mem_addr_q;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fetch_addr_d = fetch_addr_q;
        if (w_redirect) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            fetch_addr_d = w_pc_tag;
        end else begin
            if (w_push) begin
                tail_d       = tail_q + c_PTR_W'(1);
                fetch_addr_d = fetch_addr_q + 30'd1;
            end
            if (w_pop) begin
                head_d = w_next_idx;
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            tag_q[tail_q]  <= fetch_addr_q;
            data_q[tail_q] <= bus.mem_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= BOOT_ADDRESS;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_addr_q  <= BOOT_ADDRESS[31:2];
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            case (state_q)
                S_IDLE: begin
                    if (!w_redirect && (w_occupancy < c_CNT_W'(DEPTH))) begin
                        state_q       <= S_REQ;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= {fetch_addr_q, 2'b00};
                        outstanding_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Request and address stay frozen until the bus accepts them.
                    if (bus.mem_ack_i) begin
                        state_q       <= S_IDLE;
                        mem_req_q     <= 1'b0;
                        outstanding_q <= 1'b0;
                        discard_q     <= 1'b0;
                    end else if (w_redirect) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
//  Module      : tb_instr_prefetch_unit
//  Description : Directed self-checking bench for instr_prefetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_unit;

    logic clk;
    logic rst;

    instr_prefetch_unit_if bus_if ();

    instr_prefetch_unit #(
        .DEPTH        (4),
        .BOOT_ADDRESS (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        exp_resp;
        logic [31:0] exp_data;
        logic        exp_mreq;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t        tbl [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    logic        stall_en;
    logic [31:0] stall_addr;
    logic        stray;
    logic [31:0] issued [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] a, input logic f);
        @(negedge clk);
        bus_if.instruction_request_i = r;
        bus_if.instruction_addr_i    = a;
        bus_if.flush_bus_i           = f;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.instruction_request_i = 1'b0;
        bus_if.instruction_addr_i    = 32'h0;
        bus_if.flush_bus_i           = 1'b0;
        issued.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory model: acks after `lat` waiting cycles unless the address is stalled.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus_if.mem_ack_i  = 1'b0;
        bus_if.mem_data_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (stray) begin
                bus_if.mem_ack_i  = 1'b1;
                bus_if.mem_data_i = 32'hDEAD_BEEF;
            end else if (bus_if.mem_req_o && !(stall_en && bus_if.mem_addr_o == stall_addr)) begin
                if (wait_cnt >= lat) begin
                    bus_if.mem_ack_i  = 1'b1;
                    bus_if.mem_data_i = mem_word(bus_if.mem_addr_o);
                    issued.push_back(bus_if.mem_addr_o);
                    wait_cnt = 0;
                end else begin
                    bus_if.mem_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus_if.mem_ack_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        logic found;
        tbl[0] = '{1'b1, 32'h0, 1'b1, 32'h5A5A_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h0, 1'b1, 32'h5A5A_0000, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h4, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h4, 1'b1, 32'h5A5A_0004, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'h4, 1'b1, 32'h5A5A_0004, 1'b1, 32'h10};
        tbl[5] = '{1'b1, 32'h6, 1'b1, 32'h5A5A_0004, 1'b1, 32'h10};
        tbl[6] = '{1'b1, 32'h6, 1'b1, 32'h5A5A_0004, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 32'h8, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[8] = '{1'b1, 32'h8, 1'b1, 32'h5A5A_0008, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 32'h8, 1'b0, 32'h0,         1'b1, 32'h14};

        rst = 1'b1;
        lat = 1;
        stall_en = 1'b0;
        stall_addr = 32'h0;
        stray = 1'b0;
        bus_if.instruction_request_i = 1'b0;
        bus_if.instruction_addr_i    = 32'h0;
        bus_if.flush_bus_i           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_resp",  {31'h0, bus_if.instruction_response_o}, 32'h0);
        chk("rst_data",  bus_if.instruction_data_o, 32'h0);
        chk("rst_mreq",  {31'h0, bus_if.mem_req_o}, 32'h0);
        chk("rst_maddr", bus_if.mem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fill from BOOT_ADDRESS until full
        repeat (20) cyc(1'b0, 32'h0, 1'b0);
        chk("fill_count", issued.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("fill_addr", (i < issued.size()) ? issued[i] : 32'hFFFF_FFFF, 32'(4 * i));
        chk("fill_full_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);

        // Table: hits, sequential advance, held/unaligned PC, refill
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].req, tbl[i].addr, 1'b0);
            chk($sformatf("vec%0d_resp", i), {31'h0, bus_if.instruction_response_o}, {31'h0, tbl[i].exp_resp});
            chk($sformatf("vec%0d_data", i), bus_if.instruction_data_o, tbl[i].exp_data);
            chk($sformatf("vec%0d_mreq", i), {31'h0, bus_if.mem_req_o}, {31'h0, tbl[i].exp_mreq});
            if (tbl[i].exp_mreq)
                chk($sformatf("vec%0d_maddr", i), bus_if.mem_addr_o, tbl[i].exp_maddr);
        end

        // Flush while the fetch of 0x8 waits for its ack
        stall_en = 1'b1;
        stall_addr = 32'h8;
        lat = 1;
        do_reset();
        repeat (20) cyc(1'b0, 32'h0, 1'b0);
        chk("fl_pend_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("fl_pend_maddr", bus_if.mem_addr_o, 32'h8);
        cyc(1'b1, 32'h100, 1'b1);
        chk("fl_resp0", {31'h0, bus_if.instruction_response_o}, 32'h0);
        stall_en = 1'b0;
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_hold_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("fl_hold_maddr", bus_if.mem_addr_o, 32'h8);
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_resp2", {31'h0, bus_if.instruction_response_o}, 32'h0);
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_idle_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_new_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("fl_new_maddr", bus_if.mem_addr_o, 32'h100);
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_resp5", {31'h0, bus_if.instruction_response_o}, 32'h0);
        cyc(1'b1, 32'h100, 1'b0);
        chk("fl_hit_resp", {31'h0, bus_if.instruction_response_o}, 32'h1);
        chk("fl_hit_data", bus_if.instruction_data_o, 32'h5A5A_0100);

        // Redirect in the same cycle as the ack of 0x8
        stall_en = 1'b1;
        stall_addr = 32'h8;
        lat = 0;
        do_reset();
        repeat (20) cyc(1'b0, 32'h0, 1'b0);
        stall_en = 1'b0;
        cyc(1'b1, 32'h200, 1'b0);
        cyc(1'b1, 32'h200, 1'b0);
        chk("ra_idle_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
        cyc(1'b1, 32'h200, 1'b0);
        chk("ra_new_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("ra_new_maddr", bus_if.mem_addr_o, 32'h200);
        cyc(1'b1, 32'h200, 1'b0);
        chk("ra_hit_resp", {31'h0, bus_if.instruction_response_o}, 32'h1);
        chk("ra_hit_data", bus_if.instruction_data_o, 32'h5A5A_0200);

        // Steady stepping: every refill push lands on a pop cycle
        repeat (10) cyc(1'b1, 32'h200, 1'b0);
        for (int k = 1; k < 8; k++) begin
            cyc(1'b1, 32'h200 + 32'(4 * k), 1'b0);
            chk($sformatf("pp%0d_adv_resp", k), {31'h0, bus_if.instruction_response_o}, 32'h0);
            cyc(1'b1, 32'h200 + 32'(4 * k), 1'b0);
            chk($sformatf("pp%0d_hit_resp", k), {31'h0, bus_if.instruction_response_o}, 32'h1);
            chk($sformatf("pp%0d_hit_data", k), bus_if.instruction_data_o, 32'h5A5A_0200 + 32'(4 * k));
        end

        // Fetch address wraps past the top of memory
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
            found = bus_if.instruction_response_o;
        end
        chk("wrap_hit_seen", {31'h0, found}, 32'h1);
        chk("wrap_hit_data", bus_if.instruction_data_o, 32'hA5A5_FFFC);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
            found = bus_if.mem_req_o && (bus_if.mem_addr_o == 32'h0);
        end
        chk("wrap_fetch0_seen", {31'h0, found}, 32'h1);
        repeat (4) cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b1, 32'h0, 1'b0);
        chk("wrap_adv_resp", {31'h0, bus_if.instruction_response_o}, 32'h0);
        cyc(1'b1, 32'h0, 1'b0);
        chk("wrap_step_resp", {31'h0, bus_if.instruction_response_o}, 32'h1);
        chk("wrap_step_data", bus_if.instruction_data_o, 32'h5A5A_0000);

        // Asynchronous reset in the middle of a request, then a stray ack
        stall_en = 1'b1;
        stall_addr = 32'h300;
        cyc(1'b1, 32'h300, 1'b0);
        repeat (4) cyc(1'b1, 32'h300, 1'b0);
        chk("ar_pend_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("ar_pend_maddr", bus_if.mem_addr_o, 32'h300);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_mreq_drop",  {31'h0, bus_if.mem_req_o}, 32'h0);
        chk("ar_maddr_boot", bus_if.mem_addr_o, 32'h0);
        chk("ar_resp",       {31'h0, bus_if.instruction_response_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b1;
        stall_en = 1'b0;
        bus_if.instruction_request_i = 1'b1;
        bus_if.instruction_addr_i    = 32'h0;
        #2;
        chk("ar_rel_mreq", {31'h0, bus_if.mem_req_o}, 32'h0);
        @(negedge clk);
        stray = 1'b0;
        #2;
        chk("ar_boot_mreq",  {31'h0, bus_if.mem_req_o}, 32'h1);
        chk("ar_boot_maddr", bus_if.mem_addr_o, 32'h0);
        chk("ar_boot_resp0", {31'h0, bus_if.instruction_response_o}, 32'h0);
        cyc(1'b1, 32'h0, 1'b0);
        chk("ar_boot_resp", {31'h0, bus_if.instruction_response_o}, 32'h1);
        chk("ar_boot_data", bus_if.instruction_data_o, 32'h5A5A_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
